cv32e40x_div_ctrl: RTL
======================

# cv32e40x_div_ctrl

Sequencer between the EX stage and the serial divider (`cv32e40x_div`). It accepts one DIV/DIVU/REM/REMU request at a time over a valid/ready handshake and holds operands stable for the divider. It drives the divider's valid/kill and enable lines, captures the result into a response register, and answers exact repeats of the last completed operation from a one-entry result cache without launching the divider. The cache is bypassed when data-independent timing is requested.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- `clk` in 1 — clock.
- `rst_n` in 1 — asynchronous active-low reset.
- `kill_i` in 1 — flush; aborts any operation in flight.
- `req_valid_i` in 1 — request valid.
- `req_ready_o` out 1 — request accepted when high with `req_valid_i`.
- `req_operator_i` in `div_opcode_e` — DIV_DIV, DIV_DIVU, DIV_REM or DIV_REMU.
- `req_op_a_i` in 32 — dividend.
- `req_op_b_i` in 32 — divisor.
- `req_data_ind_timing_i` in 1 — data-independent timing requested for this op.
- `div_en_o` out 1 — divider enable; also enables the ALU CLZ/shifter for the divider.
- `div_valid_o` out 1 — divider `valid_i`; low means kill.
- `div_ready_i` in 1 — divider `ready_o`; unused except by assertions.
- `div_ready_o` out 1 — divider `ready_i`.
- `div_valid_i` in 1 — divider `valid_o`.
- `div_result_i` in 32 — divider `result_o`.
- `div_operator_o` out `div_opcode_e` — latched operator.
- `div_op_a_o` out 32 — latched dividend.
- `div_op_b_o` out 32 — latched divisor.
- `div_data_ind_timing_o` out 1 — latched timing flag.
- `rsp_valid_o` out 1 — result valid.
- `rsp_ready_i` in 1 — consumer ready.
- `rsp_result_o` out 32 — result.
- `rsp_cached_o` out 1 — result came from the cache (for performance counters).

## Operation
- Three-state FSM:
  - IDLE: `req_ready_o = !kill_i`.
  - On accept, latch operator, operands and timing flag. Then go to RESP on a hit, otherwise BUSY.
- Hit: cache valid, latched key (operator, op_a, op_b) equals the request key, and `req_data_ind_timing_i = 0`.
  - On a hit, load `rsp_result_o` from the cache and set `rsp_cached_o = 1`.
- BUSY:
  - `div_valid_o = div_en_o = div_ready_o = !kill_i`.
  - When `div_valid_i` is high and `kill_i` is low:
    - capture `div_result_i` into the response register;
    - write the cache (key = latched operands/operator, data = result);
    - set cache valid and `rsp_cached_o = 0`;
    - go to RESP.
- RESP: `rsp_valid_o = 1`. On `rsp_ready_i` go to IDLE. Result and `rsp_cached_o` are stable while stalled.
- Kill, checked before all else:
  - any state goes to IDLE next cycle;
  - the response is dropped and the cache is not written;
  - the cache entry is kept, because a completed result stays valid.
- Killing BUSY drives `div_valid_o` low in the same cycle, so the divider returns to its IDLE state. The next launch is at least one cycle later.
- The cache is filled regardless of the timing flag. It is only looked up when the timing flag is 0.
- Divide-by-zero and overflow results come unchanged from the divider and may be cached.
- Outputs and registers at reset:
  - state IDLE, `rsp_valid_o = 0`, `div_valid_o = 0`, `div_en_o = 0`, `div_ready_o = 0`;
  - `rsp_result_o = 0`, `rsp_cached_o = 0`, latched operands 0;
  - cache invalid.
- `req_ready_o` out of reset is 1 unless `kill_i` is high.

## Timing
- Accept in cycle T.
  - Miss: `div_valid_o` high from T+1. Divider result seen in cycle F. `rsp_valid_o` from F+1.
  - Hit: `rsp_valid_o` at T+1, and the divider is never enabled.
- Throughput: one request per response. `req_ready_o` is low in BUSY and RESP, so back-to-back hits give one result every 2 cycles.
- `kill_i` and `div_valid_i` high in the same cycle: kill wins, with no capture and no cache write.
- `kill_i` in RESP together with `rsp_ready_i`: the handshake does not complete, and `rsp_valid_o` is already 0 in that cycle.
- Asynchronous reset mid-BUSY: all outputs take their reset values immediately and the cache is invalidated.

## Structure
- `cv32e40x_pkg` holds:
  - `div_ctrl_state_e` with values DIV_CTRL_IDLE, DIV_CTRL_BUSY and DIV_CTRL_RESP;
  - the cache key struct `div_cache_key_t`: operator, op_a, op_b.
- One sub-module, `cv32e40x_div_result_cache`:
  - contents: key register, data register, valid bit;
  - ports: lookup-key compare output, write enable, clear.
- The FSM and response register live in the top module.

## Test plan
- Miss then hit:
  - DIVU 100/7 → divider launched, `rsp_result_o = 14`, `rsp_cached_o = 0`.
  - Same request again → `rsp_valid_o` at T+1, result 14, `rsp_cached_o = 1`, `div_valid_o` stays 0.
- Key mismatch: REM −7,2 then DIV −7,2 → both launch the divider, results 0xFFFFFFFF and 0xFFFFFFFD.
- Timing-flag bypass: DIVU 100/7 cached, then repeated with `req_data_ind_timing_i = 1` → divider launched, full latency, `rsp_cached_o = 0`.
- Kill mid-BUSY on DIV 1000/3:
  - `div_valid_o` low the same cycle, IDLE next cycle, no `rsp_valid_o`;
  - the cache keeps the previous entry;
  - relaunch gives 333.
- Kill coincident with `div_valid_i` → no response and no cache write; the next identical request misses.
- Backpressure: `rsp_ready_i` low for 5 cycles → `rsp_valid_o`, result and `rsp_cached_o` stable, `req_ready_o = 0`; IDLE the cycle after `rsp_ready_i` rises.
- Reset asserted in BUSY → all outputs at reset values; after release, a repeat of the last request misses.

Source files
------------

// File: rtl/cv32e40x_pkg.sv
// Shared types for the divider sequencer: opcodes, controller states and the result-cache key.
package cv32e40x_pkg;

  localparam int unsigned DIV_W = 32;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'd0,
    DIV_DIVU = 2'd1,
    DIV_REM  = 2'd2,
    DIV_REMU = 2'd3
  } div_opcode_e;

  typedef enum logic [1:0] {
    DIV_CTRL_IDLE = 2'd0,
    DIV_CTRL_BUSY = 2'd1,
    DIV_CTRL_RESP = 2'd2
  } div_ctrl_state_e;

  typedef struct packed {
    div_opcode_e      operator;
    logic [DIV_W-1:0] op_a;
    logic [DIV_W-1:0] op_b;
  } div_cache_key_t;

endpackage

// File: rtl/cv32e40x_div_result_cache.sv
// One-entry result cache holding the key and result of the last completed division.
module cv32e40x_div_result_cache
  import cv32e40x_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  div_cache_key_t   lookup_key_i,
  output logic             lookup_hit_c,
  input  logic             wr_en_i,
  input  div_cache_key_t   wr_key_i,
  input  logic [DIV_W-1:0] wr_data_i,
  output logic [DIV_W-1:0] rdata_o
);

  div_cache_key_t   key_q, key_d;
  logic [DIV_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Clear takes priority over a simultaneous write.
  always_comb begin
    key_d   = key_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (wr_en_i) begin
      key_d   = wr_key_i;
      data_d  = wr_data_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      key_q   <= key_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign lookup_hit_c = valid_q && (lookup_key_i == key_q);
  assign rdata_o      = data_q;

endmodule

// File: rtl/cv32e40x_div_ctrl.sv
// Sequencer between EX and the serial divider: operand latching, divider handshake,
// response register and a one-entry cache of the last completed result.
module cv32e40x_div_ctrl
  import cv32e40x_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             kill_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  div_opcode_e      req_operator_i,
  input  logic [DIV_W-1:0] req_op_a_i,
  input  logic [DIV_W-1:0] req_op_b_i,
  input  logic             req_data_ind_timing_i,
  output logic             div_en_o,
  output logic             div_valid_o,
  input  logic             div_ready_i,
  output logic             div_ready_o,
  input  logic             div_valid_i,
  input  logic [DIV_W-1:0] div_result_i,
  output div_opcode_e      div_operator_o,
  output logic [DIV_W-1:0] div_op_a_o,
  output logic [DIV_W-1:0] div_op_b_o,
  output logic             div_data_ind_timing_o,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DIV_W-1:0] rsp_result_o,
  output logic             rsp_cached_o
);

  div_ctrl_state_e  state_q, state_d;
  div_opcode_e      operator_q, operator_d;
  logic [DIV_W-1:0] op_a_q, op_a_d;
  logic [DIV_W-1:0] op_b_q, op_b_d;
  logic             dit_q, dit_d;
  logic [DIV_W-1:0] result_q, result_d;
  logic             cached_q, cached_d;

  div_cache_key_t   lookup_key;
  div_cache_key_t   latched_key;
  logic             cache_hit;
  logic             cache_we;
  logic [DIV_W-1:0] cache_rdata;

  assign lookup_key  = '{operator: req_operator_i, op_a: req_op_a_i, op_b: req_op_b_i};
  assign latched_key = '{operator: operator_q, op_a: op_a_q, op_b: op_b_q};

  cv32e40x_div_result_cache u_result_cache (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (1'b0),
    .lookup_key_i (lookup_key),
    .lookup_hit_c (cache_hit),
    .wr_en_i      (cache_we),
    .wr_key_i     (latched_key),
    .wr_data_i    (div_result_i),
    .rdata_o      (cache_rdata)
  );

  // Kill overrides every state; handshake outputs are all gated by it in the same cycle.
  always_comb begin
    state_d     = state_q;
    operator_d  = operator_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    dit_d       = dit_q;
    result_d    = result_q;
    cached_d    = cached_q;
    req_ready_o = 1'b0;
    div_valid_o = 1'b0;
    div_en_o    = 1'b0;
    div_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    cache_we    = 1'b0;

    if (kill_i) begin
      state_d = DIV_CTRL_IDLE;
    end else begin
      unique case (state_q)
        DIV_CTRL_IDLE: begin
          req_ready_o = 1'b1;
          if (req_valid_i) begin
            operator_d = req_operator_i;
            op_a_d     = req_op_a_i;
            op_b_d     = req_op_b_i;
            dit_d      = req_data_ind_timing_i;
            if (cache_hit && !req_data_ind_timing_i) begin
              result_d = cache_rdata;
              cached_d = 1'b1;
              state_d  = DIV_CTRL_RESP;
            end else begin
              state_d  = DIV_CTRL_BUSY;
            end
          end
        end
        DIV_CTRL_BUSY: begin
          div_valid_o = 1'b1;
          div_en_o    = 1'b1;
          div_ready_o = 1'b1;
          if (div_valid_i) begin
            result_d = div_result_i;
            cached_d = 1'b0;
            cache_we = 1'b1;
            state_d  = DIV_CTRL_RESP;
          end
        end
        DIV_CTRL_RESP: begin
          rsp_valid_o = 1'b1;
          if (rsp_ready_i) begin
            state_d = DIV_CTRL_IDLE;
          end
        end
        default: state_d = DIV_CTRL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DIV_CTRL_IDLE;
      operator_q <= DIV_DIV;
      op_a_q     <= '0;
      op_b_q     <= '0;
      dit_q      <= 1'b0;
      result_q   <= '0;
      cached_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      operator_q <= operator_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      dit_q      <= dit_d;
      result_q   <= result_d;
      cached_q   <= cached_d;
    end
  end

  assign div_operator_o        = operator_q;
  assign div_op_a_o            = op_a_q;
  assign div_op_b_o            = op_b_q;
  assign div_data_ind_timing_o = dit_q;
  assign rsp_result_o          = result_q;
  assign rsp_cached_o          = cached_q;

  // The divider only reports a result while busy, never while advertising idle.
  a_div_result_not_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !(div_valid_i && div_ready_i));
  a_div_result_in_busy: assert property (@(posedge clk) disable iff (!rst_n)
    div_valid_i |-> (state_q == DIV_CTRL_BUSY));

endmodule
